// File: rtl/profile_pkg.sv
// profile_pkg: register map, engine states, slot lengths and saturating adder shared by profile_gen_n
package profile_pkg;
  localparam logic [2:0] R_V_EFF = 3'd0, R_V_IN = 3'd1, R_V_OUT = 3'd2, R_A = 3'd3;
  localparam logic [2:0] R_J = 3'd4, R_JJ = 3'd5, R_STEPS = 3'd6, R_RSVD = 3'd7;
  localparam int SLOT_ACTIVE = 12;
  localparam int SLOT_IDLE = 3;
  localparam int MAX_W = 128;
  typedef enum logic [2:0] {CLEAR, IDLE, RD_S, RD, CALC, WR, NEXT, DONE} state_t;
  function automatic logic signed [MAX_W-1:0] sat_add(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b,
    input int w,
    input logic sat
  );
    logic signed [MAX_W-1:0] s, hi, lo;
    s = a + b;
    hi = ~(('1) << (w - 1));
    lo = ~hi;
    return !sat ? s : s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/profile_ram.sv
// profile_ram: DEPTH x WIDTH RAM, two registered-address read ports (a, b) and one write port
module profile_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] qa, qb;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    qa <= raddr_a;
    qb <= raddr_b;
  end
  assign rdata_a = mem[qa];
  assign rdata_b = mem[qb];
endmodule

// File: rtl/profile_gen_n.sv
// profile_gen_n: multi-channel jerk-limited integrator; acc_step/busy/step_overrun control, speed+done_mask out, param_* host RAM port
module profile_gen_n
  import profile_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH = 64,
  parameter int SATURATE = 0,
  localparam int ADDR_W = $clog2(CHANNELS) + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_step,
  output logic                      busy,
  output logic [CHANNELS*WIDTH-1:0] speed,
  output logic [CHANNELS-1:0]       done_mask,
  output logic                      step_overrun,
  input  logic [ADDR_W-1:0]         param_addr,
  input  logic [WIDTH-1:0]          param_in,
  input  logic                      param_write,
  output logic [WIDTH-1:0]          param_out,
  output logic                      param_reject
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int DEPTH = CHANNELS * 8;
  localparam logic [2:0] S_LAST = 3'(SLOT_IDLE - 2);
  localparam logic [2:0] WR_LAST = 3'(SLOT_ACTIVE - 8);
  state_t state, state_n;
  logic [CW-1:0] ch, ch_n, host_ch;
  logic [2:0] sub, sub_n, rreg, wreg;
  logic [ADDR_W-1:0] clr, eng_raddr, waddr;
  logic [WIDTH-1:0] eng_rd, steps_q, eng_wdata, wdata;
  logic signed [WIDTH-1:0] jj_q, j_q, a_q, v_q, j_n, a_n, v_n, ve;
  logic signed [WIDTH:0] vsum;
  logic eng_we, host_we, we;
  assign busy = state != IDLE;
  assign j_n = WIDTH'(sat_add(MAX_W'(j_q), MAX_W'(jj_q), WIDTH, SATURATE != 0));
  assign a_n = WIDTH'(sat_add(MAX_W'(a_q), MAX_W'(j_n), WIDTH, SATURATE != 0));
  assign v_n = WIDTH'(sat_add(MAX_W'(v_q), MAX_W'(a_n), WIDTH, SATURATE != 0));
  assign vsum = (WIDTH+1)'(v_q) + (WIDTH+1)'(v_n);
  assign ve = vsum[WIDTH:1];
  assign rreg = state == RD_S ? (sub == 3'd0 ? R_STEPS : R_JJ) :
                sub == 3'd0 ? R_J : sub == 3'd1 ? R_A : R_V_OUT;
  assign eng_raddr = ADDR_W'({ch, rreg});
  assign wreg = state == CALC ? R_J : sub == 3'd0 ? R_A : sub == 3'd1 ? R_V_IN :
                sub == 3'd2 ? R_V_OUT : sub == 3'd3 ? R_V_EFF : R_STEPS;
  assign eng_wdata = state == CLEAR ? '0 : state == CALC ? j_n : sub == 3'd0 ? a_n :
                     sub == 3'd1 ? v_q : sub == 3'd2 ? v_n : sub == 3'd3 ? ve : steps_q - 1'b1;
  assign eng_we = state == CLEAR || state == CALC || state == WR;
  assign host_we = param_write && state == IDLE && param_addr[2:0] != R_RSVD;
  assign host_ch = CW'(param_addr >> 3);
  assign we = eng_we || host_we;
  assign waddr = state == CLEAR ? clr : eng_we ? ADDR_W'({ch, wreg}) : param_addr;
  assign wdata = eng_we ? eng_wdata : param_in;
  profile_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ram (
    .clk     (clk),
    .raddr_a (param_addr),
    .raddr_b (eng_raddr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rdata_a (param_out),
    .rdata_b (eng_rd)
  );
  always_comb begin
    state_n = state;
    ch_n = ch;
    sub_n = sub + 3'd1;
    case (state)
      CLEAR: state_n = clr == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR;
      IDLE: begin
        sub_n = '0;
        ch_n = '0;
        state_n = acc_step ? RD_S : IDLE;
      end
      RD_S: if (sub == S_LAST) begin
        sub_n = '0;
        state_n = eng_rd == '0 ? NEXT : RD;
      end
      RD: if (sub == 3'd2) begin
        sub_n = '0;
        state_n = CALC;
      end
      CALC: begin
        sub_n = '0;
        state_n = WR;
      end
      WR: state_n = sub == WR_LAST ? NEXT : WR;
      NEXT: begin
        sub_n = '0;
        ch_n = ch + 1'b1;
        state_n = ch == CW'(CHANNELS - 1) ? DONE : RD_S;
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ch <= '0;
      sub <= '0;
      clr <= '0;
      speed <= '0;
      done_mask <= '0;
      step_overrun <= 1'b0;
      param_reject <= 1'b0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      sub <= sub_n;
      clr <= state == CLEAR ? clr + 1'b1 : '0;
      step_overrun <= acc_step && busy;
      param_reject <= param_write && busy;
      if (state == WR && sub == WR_LAST) begin
        speed[ch*WIDTH +: WIDTH] <= ve;
        if (steps_q == WIDTH'(1)) done_mask[ch] <= 1'b1;
      end
      if (host_we && param_addr[2:0] == R_STEPS) done_mask[host_ch] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (state == RD_S) steps_q <= eng_rd;
    if (state == RD && sub == 3'd0) jj_q <= eng_rd;
    if (state == RD && sub == 3'd1) j_q <= eng_rd;
    if (state == RD && sub == 3'd2) a_q <= eng_rd;
    if (state == CALC) v_q <= eng_rd;
  end
endmodule

// File: tb/tb_profile_gen_n.sv
// tb_profile_gen_n: directed self-checking bench for profile_gen_n (wrapping and saturating instances)
module tb_profile_gen_n;
  import profile_pkg::*;
  logic clk = 1'b0, rst = 1'b1, acc_step = 1'b0, param_write = 1'b0;
  logic [5:0] param_addr = '0;
  logic [63:0] param_in = '0, rv;
  logic busy, step_overrun, param_reject, busy_s, ovr_s, rej_s;
  logic [511:0] speed, speed_s;
  logic [7:0] done_mask, done_s;
  logic [63:0] param_out, pout_s;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  profile_gen_n #(.SATURATE(0)) dut (
    .clk(clk), .rst(rst), .acc_step(acc_step), .busy(busy), .speed(speed),
    .done_mask(done_mask), .step_overrun(step_overrun), .param_addr(param_addr),
    .param_in(param_in), .param_write(param_write), .param_out(param_out),
    .param_reject(param_reject)
  );
  profile_gen_n #(.SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .acc_step(acc_step), .busy(busy_s), .speed(speed_s),
    .done_mask(done_s), .step_overrun(ovr_s), .param_addr(param_addr),
    .param_in(param_in), .param_write(param_write), .param_out(pout_s),
    .param_reject(rej_s)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int c, input logic [2:0] r, input logic [63:0] d);
    param_addr = {3'(c), r};
    param_in = d;
    param_write = 1'b1;
    tick;
    param_write = 1'b0;
  endtask
  task automatic rd(input int c, input logic [2:0] r, output logic [63:0] d);
    param_addr = {3'(c), r};
    tick;
    d = param_out;
  endtask
  function automatic logic [63:0] spd(input int c);
    return speed[c*64 +: 64];
  endfunction
  task automatic wait_idle(input string tag, input int exp_w);
    int n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    chk(tag, 64'(n), 64'(exp_w));
  endtask
  task automatic run_pass(input string tag, input int exp_w);
    acc_step = 1'b1;
    tick;
    acc_step = 1'b0;
    wait_idle(tag, exp_w);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) tick;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_speed", 64'(|speed), 64'd0);
    chk("rst_done", 64'(done_mask), 64'd0);
    chk("rst_flags", 64'({step_overrun, param_reject}), 64'd0);
    rst = 1'b0;
    wait_idle("clear_len", 64);
    rd(0, R_V_OUT, rv);
    chk("clr_v0", rv, 64'd0);
    rd(7, R_STEPS, rv);
    chk("clr_s7", rv, 64'd0);
    wr(0, R_A, 64'd4);
    wr(0, R_V_OUT, 64'd100);
    wr(0, R_STEPS, 64'd3);
    run_pass("p1_len", 34);
    chk("p1_spd", spd(0), 64'd102);
    chk("p1_done", 64'(done_mask), 64'd0);
    run_pass("p2_len", 34);
    chk("p2_spd", spd(0), 64'd106);
    run_pass("p3_len", 34);
    chk("p3_spd", spd(0), 64'd110);
    chk("p3_done", 64'(done_mask), 64'd1);
    rd(0, R_V_IN, rv);
    chk("p3_vin", rv, 64'd108);
    rd(0, R_V_OUT, rv);
    chk("p3_vout", rv, 64'd112);
    rd(0, R_STEPS, rv);
    chk("p3_steps", rv, 64'd0);
    run_pass("p4_len", 25);
    chk("p4_spd", spd(0), 64'd110);
    rd(0, R_V_OUT, rv);
    chk("p4_vout", rv, 64'd112);
    rd(0, R_V_EFF, rv);
    chk("p4_veff", rv, 64'd110);
    wr(0, R_RSVD, 64'd55);
    rd(0, R_RSVD, rv);
    chk("rsvd", rv, 64'd0);
    wr(0, R_STEPS, 64'd0);
    chk("steps_clr_done", 64'(done_mask), 64'd0);
    wr(3, R_JJ, 64'd1);
    wr(3, R_STEPS, 64'd2);
    run_pass("j1_len", 34);
    rd(3, R_J, rv);
    chk("j1_j", rv, 64'd1);
    rd(3, R_A, rv);
    chk("j1_a", rv, 64'd1);
    rd(3, R_V_OUT, rv);
    chk("j1_v", rv, 64'd1);
    chk("j1_spd", spd(3), 64'd0);
    run_pass("j2_len", 34);
    rd(3, R_J, rv);
    chk("j2_j", rv, 64'd2);
    rd(3, R_A, rv);
    chk("j2_a", rv, 64'd3);
    rd(3, R_V_OUT, rv);
    chk("j2_v", rv, 64'd4);
    chk("j2_spd", spd(3), 64'd2);
    chk("j2_spd0", spd(0), 64'd110);
    chk("j2_done", 64'(done_mask), 64'h08);
    wr(1, R_V_OUT, 64'h7FFF_FFFF_FFFF_FFFE);
    wr(1, R_A, 64'd5);
    wr(1, R_STEPS, 64'd1);
    run_pass("sat_len", 34);
    rd(1, R_V_OUT, rv);
    chk("wrap_v", rv, 64'h8000_0000_0000_0003);
    chk("sat_v", pout_s, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("wrap_eff", spd(1), 64'd0);
    chk("sat_eff", speed_s[64 +: 64], 64'h7FFF_FFFF_FFFF_FFFE);
    chk("sat_flags", 64'({busy_s, ovr_s, rej_s, done_s}), 64'h00A);
    wr(2, R_V_OUT, 64'd10);
    wr(2, R_A, 64'd2);
    wr(2, R_STEPS, 64'd1);
    acc_step = 1'b1;
    tick;
    acc_step = 1'b0;
    chk("ovr_quiet", 64'(step_overrun), 64'd0);
    tick;
    tick;
    acc_step = 1'b1;
    tick;
    acc_step = 1'b0;
    chk("ovr_pulse", 64'(step_overrun), 64'd1);
    tick;
    chk("ovr_low", 64'(step_overrun), 64'd0);
    param_addr = {3'd2, R_V_OUT};
    param_in = 64'd999;
    param_write = 1'b1;
    tick;
    param_write = 1'b0;
    chk("rej_pulse", 64'(param_reject), 64'd1);
    tick;
    chk("rej_low", 64'(param_reject), 64'd0);
    wait_idle("ovr_len", 28);
    chk("ovr_spd", spd(2), 64'd11);
    rd(2, R_V_OUT, rv);
    chk("rej_vout", rv, 64'd12);
    wr(5, R_STEPS, 64'd4);
    wr(5, R_V_OUT, 64'd7);
    acc_step = 1'b1;
    tick;
    acc_step = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    chk("abort_speed", 64'(|speed), 64'd0);
    chk("abort_done", 64'(done_mask), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    wait_idle("reclear_len", 64);
    rd(0, R_V_OUT, rv);
    chk("reclr_v0", rv, 64'd0);
    rd(3, R_J, rv);
    chk("reclr_j3", rv, 64'd0);
    rd(2, R_V_OUT, rv);
    chk("reclr_v2", rv, 64'd0);
    rd(5, R_STEPS, rv);
    chk("reclr_s5", rv, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
